// File: rtl/demux_pkg.sv
// Shared constants and the slot state encoding for the 1-to-N stream demux.
package demux_pkg;

   localparam int         ERR_CNT_W   = 8;
   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with an EMPTY/FULL handshake FSM.
// A FULL slot that is being drained this cycle counts as free, so a new
// word can replace the leaving one without a bubble.
module demux_slot
   import demux_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         free
);

   slot_state_e state;

   assign out_valid = (state == SLOT_FULL);
   assign free      = (state == SLOT_EMPTY) || out_ready;

   // Slot state and data register; data changes only on load, so it stays stable while EMPTY.
   always_ff @(posedge clk) begin
      // NOTE: the data register is reset too, because out_data must read 0 after reset;
      // a register with no observable reset value could skip this.
      if (rst) begin
         state    <= SLOT_EMPTY;
         out_data <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         case (state)
            SLOT_EMPTY: begin
               if (load) begin
                  state    <= SLOT_FULL;
                  out_data <= load_data;
               end
            end
            SLOT_FULL: begin
               if (load) begin
                  out_data <= load_data;
               end else if (out_ready) begin
                  state <= SLOT_EMPTY;
               end
            end
            default: state <= SLOT_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N stream demultiplexer with broadcast, a legacy one-hot
// view of the last routing decision and a saturating drop counter.
module demux_1xn_stream
   import demux_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 8,
   localparam int SEL_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_data,
   input  logic [SEL_W-1:0]     in_sel,
   input  logic                 in_bcast,
   output logic [N-1:0]         out_valid,
   input  logic [N-1:0]         out_ready,
   output logic [N*W-1:0]       out_data,
   output logic [N-1:0]         sel_onehot,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic [N-1:0] free;
   logic [N-1:0] sel_dec;
   logic [N-1:0] load;
   logic         sel_in_range;
   logic         accept;

   // A select beyond N-1 only exists when N is not a power of two; it decodes to all zeros.
   assign sel_in_range = (int'(in_sel) < N);
   assign sel_dec      = sel_in_range ? ({{(N-1){1'b0}}, 1'b1} << in_sel) : '0;
   assign accept       = in_valid && in_ready;

   // Ready reduction and per-slot load enables; ready never looks at in_valid.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      in_ready = 1'b0;
      load     = '0;
      if (in_bcast) begin
         in_ready = &free;
         load     = accept ? '1 : '0;
      end else if (sel_in_range) begin
         in_ready = |(free & sel_dec);
         load     = accept ? sel_dec : '0;
      end else begin
         // Out-of-range words are swallowed so the producer never stalls on them.
         in_ready = 1'b1;
      end
   end

   // Last routing decision: one-hot for unicast, all ones for broadcast, held on drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_onehot <= '0;
      end else if (accept && in_bcast) begin
         sel_onehot <= '1;
      end else if (accept && sel_in_range) begin
         sel_onehot <= sel_dec;
      end
   end

   // Saturating count of words dropped for an out-of-range select.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (accept && !in_bcast && !sel_in_range && (err_cnt != ERR_CNT_MAX)) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_slot
      demux_slot #(.W(W)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (load[k]),
         .load_data (in_data),
         .out_ready (out_ready[k]),
         .out_valid (out_valid[k]),
         .out_data  (out_data[k*W +: W]),
         .free      (free[k])
      );
   end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Self-checking bench: N=8 instance for routing/backpressure/broadcast/reset,
// N=6 instance for out-of-range drops and counter saturation.
module tb_demux_1xn_stream;

   localparam int N  = 8;
   localparam int N6 = 6;
   localparam int W  = 8;

   logic clk = 1'b0;
   logic rst;

   // N=8 instance signals
   logic           in_valid, in_ready, in_bcast;
   logic [W-1:0]   in_data;
   logic [2:0]     in_sel;
   logic [N-1:0]   out_valid, out_ready, sel_onehot;
   logic [N*W-1:0] out_data;
   logic [7:0]     err_cnt;

   // N=6 instance signals
   logic            in_valid6, in_ready6, in_bcast6;
   logic [W-1:0]    in_data6;
   logic [2:0]      in_sel6;
   logic [N6-1:0]   out_valid6, out_ready6, sel_onehot6;
   logic [N6*W-1:0] out_data6;
   logic [7:0]      err_cnt6;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int         ch;
      logic [7:0] data;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      logic [2:0] sel;
      logic [7:0] data;
      logic [7:0] exp_onehot;
      logic [7:0] exp_valid;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   demux_1xn_stream #(.N(N), .W(W)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sel_onehot(sel_onehot), .err_cnt(err_cnt)
   );

   demux_1xn_stream #(.N(N6), .W(W)) u_dut6 (
      .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6),
      .in_data(in_data6), .in_sel(in_sel6), .in_bcast(in_bcast6),
      .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
      .sel_onehot(sel_onehot6), .err_cnt(err_cnt6)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] lane(input int k);
      return out_data[k*W +: W];
   endfunction

   // Present a word to the N=8 instance, check ready, and log expected loads.
   task automatic drive(input logic v, input logic [2:0] sel, input logic bc,
                        input logic [7:0] d, input logic exp_ready, input string name);
      exp_t e;
      in_valid = v;
      in_sel   = sel;
      in_bcast = bc;
      in_data  = d;
      #1;
      check({name, "_ready"}, 64'(in_ready), 64'(exp_ready));
      if (v && exp_ready) begin
         for (int k = 0; k < N; k++) begin
            if (bc || k == int'(sel)) begin
               e.ch   = k;
               e.data = d;
               exp_q.push_back(e);
            end
         end
      end
   endtask

   // Advance one edge and compare every word that should have landed.
   task automatic tick(input string name);
      exp_t e;
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("%s_valid%0d", name, e.ch), 64'(out_valid[e.ch]), 64'(1));
         check($sformatf("%s_data%0d", name, e.ch), 64'(lane(e.ch)), 64'(e.data));
      end
   endtask

   task automatic idle8();
      in_valid = 1'b0;
      in_bcast = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         vecs[i].sel        = 3'(i);
         vecs[i].data       = 8'hA0 + 8'(i);
         vecs[i].exp_onehot = 8'h01 << i;
         vecs[i].exp_valid  = 8'h01 << i;
      end

      rst = 1'b1;
      in_valid = 0; in_sel = 0; in_bcast = 0; in_data = 0; out_ready = '1;
      in_valid6 = 0; in_sel6 = 0; in_bcast6 = 0; in_data6 = 0; out_ready6 = '1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", out_data, 64'(0));
      check("rst_sel_onehot", 64'(sel_onehot), 64'(0));
      check("rst_err_cnt", 64'(err_cnt), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));

      // Unicast sweep, back-to-back, all consumers ready
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vecs[i].sel, 1'b0, vecs[i].data, 1'b1, $sformatf("sweep%0d", i));
         tick($sformatf("sweep%0d", i));
         check($sformatf("sweep%0d_onehot", i), 64'(sel_onehot), 64'(vecs[i].exp_onehot));
         check($sformatf("sweep%0d_vmask", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      end
      idle8();
      tick("sweep_end");
      check("sweep_end_valid", 64'(out_valid), 64'(0));

      // Backpressure on channel 3
      out_ready = 8'hF7;
      drive(1'b1, 3'd3, 1'b0, 8'h11, 1'b1, "bp_fill");
      tick("bp_fill");
      drive(1'b1, 3'd3, 1'b0, 8'h22, 1'b0, "bp_stall");
      tick("bp_stall");
      check("bp_hold_data", 64'(lane(3)), 64'(8'h11));
      check("bp_hold_onehot", 64'(sel_onehot), 64'(8'h08));
      drive(1'b1, 3'd5, 1'b0, 8'h55, 1'b1, "bp_other");
      tick("bp_other");
      check("bp_other_vmask", 64'(out_valid), 64'(8'h28));

      // Simultaneous drain and load on channel 2
      out_ready = 8'hF3;
      drive(1'b1, 3'd2, 1'b0, 8'h33, 1'b1, "dl_fill");
      tick("dl_fill");
      out_ready = 8'hF7;
      drive(1'b1, 3'd2, 1'b0, 8'h44, 1'b1, "dl_swap");
      tick("dl_swap");
      idle8();
      tick("dl_drain");
      check("dl_drain_valid2", 64'(out_valid[2]), 64'(0));
      check("dl_drain_data2", 64'(lane(2)), 64'(8'h44));

      // Broadcast from all-empty, then against a stalled slot 6
      out_ready = 8'hFF;
      tick("bc_flush");
      check("bc_flush_valid", 64'(out_valid), 64'(0));
      out_ready = 8'hBF;
      drive(1'b1, 3'd3, 1'b1, 8'h5A, 1'b1, "bc_ok");
      tick("bc_ok");
      check("bc_ok_vmask", 64'(out_valid), 64'(8'hFF));
      check("bc_ok_onehot", 64'(sel_onehot), 64'(8'hFF));
      idle8();
      tick("bc_drain");
      check("bc_drain_vmask", 64'(out_valid), 64'(8'h40));
      drive(1'b1, 3'd0, 1'b1, 8'h77, 1'b0, "bc_block");
      tick("bc_block");
      check("bc_block_vmask", 64'(out_valid), 64'(8'h40));
      check("bc_block_lane0", 64'(lane(0)), 64'(8'h5A));
      check("bc_block_lane6", 64'(lane(6)), 64'(8'h5A));
      drive(1'b1, 3'd1, 1'b0, 8'h66, 1'b1, "indep");
      tick("indep");
      check("indep_onehot", 64'(sel_onehot), 64'(8'h02));
      idle8();
      tick("indep_drain");

      // Out-of-range selects on the N=6 instance
      for (int i = 0; i < 300; i++) begin
         in_valid6 = 1'b1;
         in_sel6   = (i % 2 == 0) ? 3'd6 : 3'd7;
         in_data6  = 8'(i);
         #1;
         check($sformatf("oor%0d_ready", i), 64'(in_ready6), 64'(1));
         @(posedge clk);
         #1;
         if (i == 0) check("oor_first_cnt", 64'(err_cnt6), 64'(1));
         if (i == 253) check("oor_254_cnt", 64'(err_cnt6), 64'(254));
      end
      in_valid6 = 1'b0;
      check("oor_sat_cnt", 64'(err_cnt6), 64'(255));
      check("oor_valid", 64'(out_valid6), 64'(0));
      check("oor_onehot", 64'(sel_onehot6), 64'(0));

      // Mid-operation reset with channels 1, 4 (and stalled 6) full
      out_ready = 8'h00;
      drive(1'b1, 3'd1, 1'b0, 8'h61, 1'b1, "mr_fill1");
      tick("mr_fill1");
      drive(1'b1, 3'd4, 1'b0, 8'h64, 1'b1, "mr_fill4");
      tick("mr_fill4");
      check("mr_pre_vmask", 64'(out_valid), 64'(8'h52));
      in_valid = 1'b1; in_sel = 3'd0; in_bcast = 1'b0; in_data = 8'h99;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle8();
      check("mr_out_valid", 64'(out_valid), 64'(0));
      check("mr_out_data", out_data, 64'(0));
      check("mr_sel_onehot", 64'(sel_onehot), 64'(0));
      check("mr_err_cnt6", 64'(err_cnt6), 64'(0));
      tick("mr_after");
      check("mr_after_valid", 64'(out_valid), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
